// File: rtl/lcb_packet_rx_if.sv
// Byte-stream and framed-output signals of the LCB packet receiver.
// slave: the framer itself; master: the UART side / consumer that drives and observes it.
interface lcb_packet_rx_if;
    logic [7:0] rxData;
    logic       rxValid;
    logic [4:0] rqNumber;
    logic [7:0] oData;
    logic [4:0] oIdx;
    logic [4:0] oNum;
    logic       oValid;
    logic       oLast;
    logic       oErr;
    logic [1:0] oErrCode;
    logic [7:0] oErrCnt;
    logic       oBusy;

    modport slave (
        input  rxData, rxValid, rqNumber,
        output oData, oIdx, oNum, oValid, oLast, oErr, oErrCode, oErrCnt, oBusy
    );

    modport master (
        output rxData, rxValid, rqNumber,
        input  oData, oIdx, oNum, oValid, oLast, oErr, oErrCode, oErrCnt, oBusy
    );
endinterface

// File: rtl/lcb_packet_rx.sv
// LCB packet framer: SYNC/LEN/payload[/checksum], payload released as an indexed burst only once valid.
// Define LCB_PKT_CHK_EN to expect and verify a trailing checksum byte; undefined drains right after the payload.
module lcb_packet_rx #(
    parameter logic [7:0] SYNC_BYTE   = 8'h7E,
    parameter int         MAX_LEN     = 32,
    parameter int         TIMEOUT_CYC = 8000
) (
    input  logic           clk,
    input  logic           reset,
    lcb_packet_rx_if.slave bus
);
    localparam int            TW        = $clog2(TIMEOUT_CYC);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
`ifdef LCB_PKT_CHK_EN
        S_CHK,
`endif
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    len_q, len_d;
    logic [5:0]    ptr_q, ptr_d;
    logic [7:0]    sum_q, sum_d;
    logic [4:0]    num_lat_q, num_lat_d;
    logic [TW-1:0] idle_q, idle_d;

    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    num_q, num_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          busy_q, busy_d;

    logic [7:0]    buf_q [32];
    logic          wr_en;
    logic          start_drain;
    logic          waiting;
    logic [7:0]    first_byte;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        num_lat_d   = num_lat_q;
        idle_d      = '0;
        valid_d     = 1'b0;
        data_d      = '0;
        idx_d       = '0;
        num_d       = '0;
        last_d      = 1'b0;
        err_d       = 1'b0;
        code_d      = '0;
        wr_en       = 1'b0;
        start_drain = 1'b0;
        waiting     = (state_q == S_LEN) || (state_q == S_PAYLOAD);
`ifdef LCB_PKT_CHK_EN
        if (state_q == S_CHK) waiting = 1'b1;
`endif
        // Without a checksum stage, a 1-byte payload is still in flight on the cycle it must be emitted.
        first_byte = (state_q == S_PAYLOAD && ptr_q == 6'd0) ? bus.rxData : buf_q[0];

        case (state_q)
            S_HUNT: begin
                if (bus.rxValid && bus.rxData == SYNC_BYTE) begin
                    num_lat_d = bus.rqNumber;
                    sum_d     = '0;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.rxValid) begin
                    if (bus.rxData == 8'd0 || bus.rxData > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = S_HUNT;
                    end else begin
                        len_d   = bus.rxData[5:0];
                        sum_d   = bus.rxData;
                        ptr_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.rxValid) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + bus.rxData;
                    ptr_d = ptr_q + 6'd1;
                    if (ptr_q + 6'd1 == len_q) begin
`ifdef LCB_PKT_CHK_EN
                        state_d = S_CHK;
`else
                        start_drain = 1'b1;
`endif
                    end
                end
            end
`ifdef LCB_PKT_CHK_EN
            S_CHK: begin
                if (bus.rxValid) begin
                    if (bus.rxData == sum_q) begin
                        start_drain = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = S_HUNT;
                    end
                end
            end
`endif
            S_DRAIN: begin
                // One extra DRAIN cycle after the last beat keeps oBusy high until the burst is fully seen.
                if (ptr_q == len_q) begin
                    state_d = S_HUNT;
                end else begin
                    valid_d = 1'b1;
                    data_d  = buf_q[ptr_q[4:0]];
                    idx_d   = ptr_q[4:0];
                    num_d   = num_lat_q;
                    last_d  = (ptr_q + 6'd1 == len_q);
                    ptr_d   = ptr_q + 6'd1;
                end
                if (bus.rxValid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: state_d = S_HUNT;
        endcase

        // Beat 0 is issued on the accepting edge so the burst starts one cycle after the final byte.
        if (start_drain) begin
            state_d = S_DRAIN;
            ptr_d   = 6'd1;
            valid_d = 1'b1;
            data_d  = first_byte;
            idx_d   = '0;
            num_d   = num_lat_q;
            last_d  = (len_q == 6'd1);
        end

        if (waiting && !bus.rxValid) begin
            if (idle_q == IDLE_LAST) begin
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                state_d = S_HUNT;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end

        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        busy_d    = (state_d != S_HUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_HUNT;
            len_q     <= '0;
            ptr_q     <= '0;
            sum_q     <= '0;
            num_lat_q <= '0;
            idle_q    <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
            num_q     <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            sum_q     <= sum_d;
            num_lat_q <= num_lat_d;
            idle_q    <= idle_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            last_q    <= last_d;
            err_q     <= err_d;
            code_q    <= code_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[ptr_q[4:0]] <= bus.rxData;
    end

    assign bus.oData    = data_q;
    assign bus.oIdx     = idx_q;
    assign bus.oNum     = num_q;
    assign bus.oValid   = valid_q;
    assign bus.oLast    = last_q;
    assign bus.oErr     = err_q;
    assign bus.oErrCode = code_q;
    assign bus.oErrCnt  = err_cnt_q;
    assign bus.oBusy    = busy_q;
endmodule

// File: tb/tb_lcb_packet_rx.sv
// Scoreboard bench for lcb_packet_rx: packet-level model pushes expected beats/errors, monitor pops on output.
module tb_lcb_packet_rx;
    localparam logic [7:0] SYNC = 8'h7E;
`ifdef LCB_PKT_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic [4:0] idx;
        logic [4:0] num;
        logic       last;
    } beat_t;
    typedef logic [7:0] bytes_t [$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcb_packet_rx_if bus ();
    lcb_packet_rx dut (.clk(clk), .reset(reset), .bus(bus));

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_err_cyc = -1;
    int         exp_cnt = 0;
    beat_t      exp_q [$];
    logic [1:0] err_q [$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat or an error.
    beat_t      e;
    logic [1:0] ec;
    bit         prev_valid = 1'b0;
    bit         busy_chk = 1'b0;
    always @(negedge clk) begin
        if (bus.oValid) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("beat_data", int'(bus.oData), int'(e.data));
                chk("beat_idx",  int'(bus.oIdx),  int'(e.idx));
                chk("beat_num",  int'(bus.oNum),  int'(e.num));
                chk("beat_last", int'(bus.oLast), int'(e.last));
                if (e.idx != 5'd0) chk("beat_gap", int'(prev_valid), 1);
            end
        end else begin
            chk("idle_zero", int'({bus.oData, bus.oIdx, bus.oNum, bus.oLast}), 0);
        end
        if (busy_chk) chk("busy_after_drain", int'(bus.oBusy), 0);
        busy_chk = bus.oValid && bus.oLast;
        if (bus.oErr) begin
            last_err_cyc = cyc;
            if (exp_cnt < 255) exp_cnt++;
            if (err_q.size() == 0) chk("unexpected_err", int'(bus.oErrCode), -1);
            else begin
                ec = err_q.pop_front();
                chk("err_code", int'(bus.oErrCode), int'(ec));
            end
            chk("err_cnt", int'(bus.oErrCnt), exp_cnt);
        end
        prev_valid = bus.oValid;
    end

    task automatic send(input logic [7:0] b, input logic [4:0] num);
        bus.rxData   = b;
        bus.rxValid  = 1'b1;
        bus.rqNumber = num;
        @(negedge clk);
        bus.rxValid  = 1'b0;
        bus.rxData   = 8'($urandom);
        bus.rqNumber = 5'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic bytes_t rand_pl(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Packet-level model: a valid packet yields its payload as indexed beats tagged with num,
    // an out-of-range length yields code 1, a wrong checksum yields code 2.
    task automatic send_pkt(input logic [4:0] num, input logic [7:0] len_b, input bytes_t pl,
                            input bit bad_chk, input int inject);
        logic [7:0] sum;
        beat_t      b;
        if (len_b == 8'd0 || len_b > 8'd32) begin
            err_q.push_back(2'd1);
            send(SYNC, num);
            gap();
            send(len_b, 5'($urandom));
            gap();
            return;
        end
        sum = len_b;
        foreach (pl[i]) sum = sum + pl[i];
        if (CHK_EN && bad_chk) err_q.push_back(2'd2);
        else begin
            foreach (pl[i]) begin
                b.data = pl[i];
                b.idx  = 5'(i);
                b.num  = num;
                b.last = (i == pl.size() - 1);
                exp_q.push_back(b);
            end
        end
        send(SYNC, num);
        gap();
        send(len_b, 5'($urandom));
        foreach (pl[i]) begin
            gap();
            send(pl[i], 5'($urandom));
        end
        if (CHK_EN) begin
            gap();
            send(bad_chk ? (sum ^ 8'h5A) : sum, 5'($urandom));
        end
        if (inject >= 0) begin
            repeat (inject) @(negedge clk);
            err_q.push_back(2'd0);
            send(8'($urandom), 5'($urandom));
        end
        repeat (int'(len_b) + 4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_oData"},    int'(bus.oData), 0);
        chk({tag, "_oIdx"},     int'(bus.oIdx), 0);
        chk({tag, "_oNum"},     int'(bus.oNum), 0);
        chk({tag, "_oValid"},   int'(bus.oValid), 0);
        chk({tag, "_oLast"},    int'(bus.oLast), 0);
        chk({tag, "_oErr"},     int'(bus.oErr), 0);
        chk({tag, "_oErrCode"}, int'(bus.oErrCode), 0);
        chk({tag, "_oErrCnt"},  int'(bus.oErrCnt), 0);
        chk({tag, "_oBusy"},    int'(bus.oBusy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    bytes_t     pl;
    bytes_t     none;
    int         t_last;
    int         kind;
    logic [7:0] lb;
    logic [4:0] rn;

    initial begin
        bus.rxData   = '0;
        bus.rxValid  = 1'b0;
        bus.rqNumber = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        pl = {8'h11, 8'h22, 8'h33};
        send_pkt(5'd5, 8'd3, pl, 1'b0, -1);
        send_pkt(5'd6, 8'd3, pl, 1'b1, -1);
        send_pkt(5'd7, 8'd4, rand_pl(4), 1'b0, -1);

        send(8'h55, 5'd1);
        send(8'hAA, 5'd1);
        send_pkt(5'd2, 8'h00, none, 1'b0, -1);
        send_pkt(5'd3, 8'h21, none, 1'b0, -1);

        err_q.push_back(2'd3);
        send(SYNC, 5'd4);
        send(8'h02, 5'd4);
        send(8'h11, 5'd4);
        t_last = cyc;
        for (int i = 0; i < 9000 && last_err_cyc < t_last; i++) @(negedge clk);
        chk("timeout_latency", last_err_cyc - t_last, 8000);
        pl = {8'h44};
        send_pkt(5'd8, 8'd1, pl, 1'b0, -1);

        send_pkt(5'd9, 8'd32, rand_pl(32), 1'b0, int'($urandom_range(1, 28)));

        send(SYNC, 5'd10);
        send(8'd5, 5'd10);
        send(8'hA1, 5'd10);
        send(8'hA2, 5'd10);
        reset = 1'b1;
        exp_q.delete();
        err_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        send(8'hA3, 5'd10);
        send(8'hA4, 5'd10);
        send(8'hA5, 5'd10);
        repeat (10) @(negedge clk);
        send_pkt(5'd11, 8'd6, rand_pl(6), 1'b0, -1);

        for (int k = 0; k < 30; k++) begin
            kind = int'($urandom_range(0, 3));
            rn   = 5'($urandom);
            lb   = 8'($urandom_range(1, 32));
            case (kind)
                0: send_pkt(rn, lb, rand_pl(int'(lb)), 1'b0, -1);
                1: begin
                    lb = $urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(33, 255));
                    send_pkt(rn, lb, none, 1'b0, -1);
                end
                2: send_pkt(rn, lb, rand_pl(int'(lb)), 1'b1, -1);
                default: begin
                    for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                        send((8'($urandom) == SYNC) ? 8'h55 : 8'($urandom) & 8'h7D, 5'($urandom));
                        gap();
                    end
                    send_pkt(rn, lb, rand_pl(int'(lb)), 1'b0, -1);
                end
            endcase
        end

        for (int i = 0; i < 200 && (exp_q.size() != 0 || err_q.size() != 0); i++) @(negedge clk);
        chk("beats_left", exp_q.size(), 0);
        chk("errs_left", err_q.size(), 0);
        chk("final_busy", int'(bus.oBusy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
